// File: rtl/mdu_core_pkg.sv
// Shared CPU constants for the multiply/divide unit.
// The E-stage decoder uses the same op encodings.
package mdu_core_pkg;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MADD  = 3'd4,
        MDU_MADDU = 3'd5,
        MDU_MSUB  = 3'd6,
        MDU_MSUBU = 3'd7
    } mdu_op_e;

    localparam int MDU_MULT_LAT = 5;
    localparam int MDU_DIV_LAT  = 10;

    function automatic logic mdu_is_div(input mdu_op_e op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic mdu_is_signed(input mdu_op_e op);
        logic sgn;
        case (op)
            MDU_MULT, MDU_DIV, MDU_MADD, MDU_MSUB: sgn = 1'b1;
            default:                               sgn = 1'b0;
        endcase
        return sgn;
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational {HI,LO} result generation from the latched operation.
// Signed division runs on magnitudes and then restores the signs.
module mdu_calc
    import mdu_core_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  mdu_op_e          op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

    logic                 sgn_s;
    logic                 a_neg_s;
    logic                 b_neg_s;
    logic [2*WIDTH-1:0]   a_ext_s;
    logic [2*WIDTH-1:0]   b_ext_s;
    logic [2*WIDTH-1:0]   prod_s;
    logic [2*WIDTH-1:0]   acc_s;
    logic [WIDTH-1:0]     a_mag_s;
    logic [WIDTH-1:0]     b_mag_s;
    logic [WIDTH-1:0]     divisor_s;
    logic [WIDTH-1:0]     quot_mag_s;
    logic [WIDTH-1:0]     rem_mag_s;
    logic [WIDTH-1:0]     quot_s;
    logic [WIDTH-1:0]     rem_s;

    // Low 2W bits of the product of sign-extended operands equal the signed product.
    assign sgn_s   = mdu_is_signed(op_i);
    assign a_neg_s = sgn_s & a_i[WIDTH-1];
    assign b_neg_s = sgn_s & b_i[WIDTH-1];
    assign a_ext_s = {{WIDTH{a_neg_s}}, a_i};
    assign b_ext_s = {{WIDTH{b_neg_s}}, b_i};
    assign prod_s  = a_ext_s * b_ext_s;
    assign acc_s   = {hi_i, lo_i};

    assign a_mag_s    = a_neg_s ? (~a_i + ONE_W) : a_i;
    assign b_mag_s    = b_neg_s ? (~b_i + ONE_W) : b_i;
    assign divisor_s  = (b_i == '0) ? ONE_W : b_mag_s;
    assign quot_mag_s = a_mag_s / divisor_s;
    assign rem_mag_s  = a_mag_s % divisor_s;
    assign quot_s     = (a_neg_s ^ b_neg_s) ? (~quot_mag_s + ONE_W) : quot_mag_s;
    assign rem_s      = a_neg_s ? (~rem_mag_s + ONE_W) : rem_mag_s;

    // Result select per operation class.
    always_comb begin
        hi_o = hi_i;
        lo_o = lo_i;
        case (op_i)
            MDU_MULT, MDU_MULTU: {hi_o, lo_o} = prod_s;
            MDU_MADD, MDU_MADDU: {hi_o, lo_o} = acc_s + prod_s;
            MDU_MSUB, MDU_MSUBU: {hi_o, lo_o} = acc_s - prod_s;
            MDU_DIV, MDU_DIVU: begin
                if (b_i == '0) begin
                    hi_o = a_i;
                    lo_o = '1;
                end else begin
                    hi_o = rem_s;
                    lo_o = quot_s;
                end
            end
            default: begin
                hi_o = hi_i;
                lo_o = lo_i;
            end
        endcase
    end

endmodule

// File: rtl/mdu_core.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Busy is a down-counter; the result commits on the edge where it reaches zero.
module mdu_core
    import mdu_core_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = MDU_MULT_LAT,
    parameter int DIV_LAT  = MDU_DIV_LAT
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Wr_hi,
    input  logic             Wr_lo,
    input  logic [WIDTH-1:0] Wd,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Busy,
    output logic             Done
);

    localparam logic [4:0] MULT_CNT = 5'(MULT_LAT);
    localparam logic [4:0] DIV_CNT  = 5'(DIV_LAT);

    logic [4:0]       cnt_q, cnt_d;
    mdu_op_e          op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] hi_lat_q, hi_lat_d;
    logic [WIDTH-1:0] lo_lat_q, lo_lat_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             busy_s;
    mdu_op_e          op_in_s;
    logic [WIDTH-1:0] res_hi_s;
    logic [WIDTH-1:0] res_lo_s;

    assign busy_s  = (cnt_q != 5'd0);
    assign op_in_s = mdu_op_e'(Op);

    mdu_calc #(
        .WIDTH (WIDTH)
    ) u_calc (
        .op_i (op_q),
        .a_i  (a_q),
        .b_i  (b_q),
        .hi_i (hi_lat_q),
        .lo_i (lo_lat_q),
        .hi_o (res_hi_s),
        .lo_o (res_lo_s)
    );

    // Next state: count down while busy, else issue (Start beats MTHI/MTLO), else MTHI/MTLO.
    always_comb begin
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        hi_lat_d = hi_lat_q;
        lo_lat_d = lo_lat_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        if (busy_s) begin
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd1) begin
                hi_d   = res_hi_s;
                lo_d   = res_lo_s;
                done_d = 1'b1;
            end else begin
                done_d = 1'b0;
            end
        end else if (Start) begin
            cnt_d    = mdu_is_div(op_in_s) ? DIV_CNT : MULT_CNT;
            op_d     = op_in_s;
            a_d      = A;
            b_d      = B;
            hi_lat_d = hi_q;
            lo_lat_d = lo_q;
        end else begin
            if (Wr_hi) hi_d = Wd;
            else       hi_d = hi_q;
            if (Wr_lo) lo_d = Wd;
            else       lo_d = lo_q;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            cnt_q    <= 5'd0;
            op_q     <= MDU_MULT;
            a_q      <= '0;
            b_q      <= '0;
            hi_lat_q <= '0;
            lo_lat_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            hi_lat_q <= hi_lat_d;
            lo_lat_q <= lo_lat_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign Hi   = hi_q;
    assign Lo   = lo_q;
    assign Busy = busy_s;
    assign Done = done_q;

endmodule
